writeback_ctrl: RTL and testbench
=================================

Name: writeback_ctrl

Overview:
Sequences the end-of-iteration centroid write-back. It is started by the scheduler's write-back start and answers with write-back done. For each of K clusters it reads the accumulated per-dimension sums and the point count. It divides each sum by the count through a shared serial divider and writes the new centroid into centroid memory. A cluster with zero count keeps its old centroid.

Parameters:
DIMENSION, 4, number of coordinates per point
PRECISION, 16, bits per coordinate
DATA_WIDTH, PRECISION*DIMENSION, packed centroid width
K, 10, number of clusters
ADDR_BITS, 4, cluster address width (2**ADDR_BITS >= K)
SUM_WIDTH, 32, bits per accumulated coordinate sum (signed)
CNT_WIDTH, 16, bits of point count (unsigned)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
i_start  in  1  level start request from scheduler (held during COLLECT)
o_done  out  1  one-cycle pulse when all K centroids are written
o_busy  out  1  high in every state except IDLE
o_acc_rd_en  out  1  read strobe to accumulator and old-centroid memories
o_acc_rd_addr  out  ADDR_BITS  cluster index being read
i_acc_sum  in  SUM_WIDTH*DIMENSION  packed sums, valid 1 cycle after rd_en
i_acc_cnt  in  CNT_WIDTH  point count, valid 1 cycle after rd_en
i_old_centroid  in  DATA_WIDTH  current centroid, valid 1 cycle after rd_en
o_div_valid  out  1  divider request valid
o_div_dividend  out  SUM_WIDTH  signed sum of current lane
o_div_divisor  out  CNT_WIDTH  latched count
i_div_ready  in  1  divider accepts request when high with o_div_valid
i_div_result_valid  in  1  quotient valid
i_div_result  in  PRECISION  quotient, already truncated to PRECISION
o_cent_wr_en  out  1  centroid memory write strobe
o_cent_wr_addr  out  ADDR_BITS  cluster index written
o_cent_wr_data  out  DATA_WIDTH  new centroid

Behaviour:
- Clock is clk. Reset is reset_n, synchronous, active-low.
- Reset: state IDLE, k=0, d=0, data registers 0. All outputs are 0.
- Strobes and o_busy/o_done are decoded from the state (Moore). Addresses are driven from k. Data comes from registers.
- Lane packing: lane d occupies bits [d*PRECISION +: PRECISION] and lane 0 is the LSBs. Sums use the same packing with SUM_WIDTH bits per lane.
- IDLE: k=0, d=0. If i_start=1, go to READ.
- READ: o_acc_rd_en=1 with addr=k. Go to LATCH.
- LATCH: capture sum, cnt and old centroid.
  - cnt==0: wr_data = old centroid, go to WRITE.
  - otherwise: d=0, go to DIV_REQ.
- DIV_REQ: o_div_valid=1, dividend = sum lane d, divisor = latched cnt. These stay stable until i_div_ready=1, then go to DIV_WAIT.
- DIV_WAIT: a result_valid arriving in the same cycle as the DIV_REQ handshake is ignored. On i_div_result_valid, write i_div_result into lane d of wr_data.
  - d==DIMENSION-1: go to WRITE.
  - otherwise: d++, go to DIV_REQ.
- WRITE: o_cent_wr_en=1 for exactly one cycle, addr=k.
  - k==K-1: go to DONE.
  - otherwise: k++, go to READ.
- DONE: o_done=1 for one cycle, then go to WAIT_LOW.
- WAIT_LOW: o_busy=1. Stay until i_start==0, then go to IDLE. This prevents a held start from re-triggering.
- Minimum latency:
  - Zero-count cluster: 3 cycles (READ, LATCH, WRITE).
  - Non-zero cluster, divider ready immediately with 1-cycle result: 3 + 2*DIMENSION cycles.
- Boundaries:
  - i_start dropping mid-run is ignored; the run completes.
  - Reset mid-run returns to IDLE immediately with no further write.
  - Exactly K writes per run, addresses 0..K-1 in order. The k counter never wraps past K-1.
- Divider handshake: no second request is issued before the previous result returns.

Test Plan:
- All K=10 counts 0, old centroid = index replicated per lane, divider idle -> 10 writes of old data, addr 0..9. Last wr_en occurs 30 cycles after start. o_done pulses once. o_div_valid never asserted.
- Cluster 3 sums {100,200,-40,8}, cnt=4, divider ready with 1-cycle result -> dividends 100,200,-40,8 in order, divisor 4. Write at addr 3 with lanes {25,50,-10,2}.
- Divider ready held low 5 cycles per request -> dividend and divisor stable throughout. Only one request per lane; results land in the correct lanes.
- Spurious i_div_result_valid during the DIV_REQ handshake cycle -> ignored; the lane takes the next result.
- i_start held high 20 cycles after o_done -> no second run, o_busy stays 1. IDLE is re-entered the cycle after i_start falls.
- reset_n low during cluster 5 division -> all outputs 0 the next cycle, no write at addr 5. A fresh start restarts from addr 0.

Source files
------------

// File: rtl/writeback_ctrl.sv
//------------------------------------------------------------------------------
// Module      : writeback_ctrl
// Description : Sequences centroid write-back: per cluster, divides each
//               coordinate sum by the point count on a shared serial divider.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module writeback_ctrl #(
    parameter int DIMENSION  = 4,
    parameter int PRECISION  = 16,
    parameter int DATA_WIDTH = PRECISION * DIMENSION,
    parameter int K          = 10,
    parameter int ADDR_BITS  = 4,
    parameter int SUM_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_start,
    output logic                           o_done,
    output logic                           o_busy,
    output logic                           o_acc_rd_en,
    output logic [ADDR_BITS-1:0]           o_acc_rd_addr,
    input  logic [SUM_WIDTH*DIMENSION-1:0] i_acc_sum,
    input  logic [CNT_WIDTH-1:0]           i_acc_cnt,
    input  logic [DATA_WIDTH-1:0]          i_old_centroid,
    output logic                           o_div_valid,
    output logic [SUM_WIDTH-1:0]           o_div_dividend,
    output logic [CNT_WIDTH-1:0]           o_div_divisor,
    input  logic                           i_div_ready,
    input  logic                           i_div_result_valid,
    input  logic [PRECISION-1:0]           i_div_result,
    output logic                           o_cent_wr_en,
    output logic [ADDR_BITS-1:0]           o_cent_wr_addr,
    output logic [DATA_WIDTH-1:0]          o_cent_wr_data
);

    localparam int                   c_D_BITS = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam logic [c_D_BITS-1:0]  c_D_LAST = c_D_BITS'(DIMENSION - 1);
    localparam logic [ADDR_BITS-1:0] c_K_LAST = ADDR_BITS'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_LATCH    = 3'd2,
        S_DIV_REQ  = 3'd3,
        S_DIV_WAIT = 3'd4,
        S_WRITE    = 3'd5,
        S_DONE     = 3'd6,
        S_WAIT_LOW = 3'd7
    } state_t;

    state_t                         r_state;
    logic [ADDR_BITS-1:0]           r_k;
    logic [c_D_BITS-1:0]            r_d;
    logic [SUM_WIDTH*DIMENSION-1:0] r_sum;
    logic [CNT_WIDTH-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]          r_wr_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_d       <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_k <= '0;
                    r_d <= '0;
                    if (i_start) r_state <= S_READ;
                end
                S_READ: r_state <= S_LATCH;
                S_LATCH: begin
                    r_sum <= i_acc_sum;
                    r_cnt <= i_acc_cnt;
                    r_d   <= '0;
                    // An empty cluster keeps its previous centroid untouched.
                    if (i_acc_cnt == '0) begin
                        r_wr_data <= i_old_centroid;
                        r_state   <= S_WRITE;
                    end else begin
                        r_wr_data <= '0;
                        r_state   <= S_DIV_REQ;
                    end
                end
                S_DIV_REQ: begin
                    if (i_div_ready) r_state <= S_DIV_WAIT;
                end
                S_DIV_WAIT: begin
                    if (i_div_result_valid) begin
                        r_wr_data[r_d*PRECISION +: PRECISION] <= i_div_result;
                        if (r_d == c_D_LAST) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_d     <= r_d + c_D_BITS'(1);
                            r_state <= S_DIV_REQ;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_k == c_K_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k + ADDR_BITS'(1);
                        r_state <= S_READ;
                    end
                end
                S_DONE: r_state <= S_WAIT_LOW;
                // Hold here until start drops so a level start cannot re-trigger.
                S_WAIT_LOW: begin
                    if (!i_start) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_acc_rd_en    = (r_state == S_READ);
    assign o_div_valid    = (r_state == S_DIV_REQ);
    assign o_cent_wr_en   = (r_state == S_WRITE);
    assign o_acc_rd_addr  = r_k;
    assign o_cent_wr_addr = r_k;
    assign o_div_dividend = r_sum[r_d*SUM_WIDTH +: SUM_WIDTH];
    assign o_div_divisor  = r_cnt;
    assign o_cent_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_writeback_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_writeback_ctrl
// Description : Scoreboard bench for writeback_ctrl with memory and divider models.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_ctrl;

    localparam int D  = 4;
    localparam int P  = 16;
    localparam int DW = 64;
    localparam int KC = 10;
    localparam int AB = 4;
    localparam int SW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            i_start;
    logic            o_done, o_busy, o_acc_rd_en, o_div_valid, o_cent_wr_en;
    logic [AB-1:0]   o_acc_rd_addr, o_cent_wr_addr;
    logic [SW*D-1:0] i_acc_sum = '0;
    logic [CW-1:0]   i_acc_cnt = '0;
    logic [DW-1:0]   i_old_centroid = '0;
    logic [SW-1:0]   o_div_dividend;
    logic [CW-1:0]   o_div_divisor;
    logic            i_div_ready, i_div_result_valid;
    logic [P-1:0]    i_div_result;
    logic [DW-1:0]   o_cent_wr_data;

    writeback_ctrl #(
        .DIMENSION(D), .PRECISION(P), .DATA_WIDTH(DW), .K(KC),
        .ADDR_BITS(AB), .SUM_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_done(o_done), .o_busy(o_busy),
        .o_acc_rd_en(o_acc_rd_en), .o_acc_rd_addr(o_acc_rd_addr), .i_acc_sum(i_acc_sum),
        .i_acc_cnt(i_acc_cnt), .i_old_centroid(i_old_centroid), .o_div_valid(o_div_valid),
        .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor), .i_div_ready(i_div_ready),
        .i_div_result_valid(i_div_result_valid), .i_div_result(i_div_result),
        .o_cent_wr_en(o_cent_wr_en), .o_cent_wr_addr(o_cent_wr_addr), .o_cent_wr_data(o_cent_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AB-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { logic [SW-1:0] dvd; logic [CW-1:0] dvs; } div_t;
    wr_t  exp_wr[$];
    div_t exp_div[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int ready_delay = 0;
    bit spurious = 1'b0;

    logic [SW*D-1:0] m_sum[KC];
    logic [CW-1:0]   m_cnt[KC];
    logic [DW-1:0]   m_old[KC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event, expected none/other (cycle %0d)", name, cyc);
    endtask

    function automatic logic [DW-1:0] p16(input int a, input int b, input int c, input int e);
        return {16'(e), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [SW*D-1:0] p32(input int a, input int b, input int c, input int e);
        return {32'(e), 32'(c), 32'(b), 32'(a)};
    endfunction

    // Accumulator / old-centroid memory: data appears one cycle after rd_en.
    always @(negedge clk) begin
        if (o_acc_rd_en) begin
            i_acc_sum      = m_sum[o_acc_rd_addr];
            i_acc_cnt      = m_cnt[o_acc_rd_addr];
            i_old_centroid = m_old[o_acc_rd_addr];
        end
    end

    // Serial divider model: optional ready stall, optional junk result in the handshake cycle.
    logic signed [31:0] dvd, q;
    logic [CW-1:0]      dvs;
    initial begin
        i_div_ready = 1'b0;
        i_div_result_valid = 1'b0;
        i_div_result = '0;
        forever begin
            @(posedge clk); #1;
            while (o_div_valid) begin
                repeat (ready_delay) begin @(posedge clk); #1; end
                dvd = o_div_dividend;
                dvs = o_div_divisor;
                i_div_ready = 1'b1;
                if (spurious) begin
                    i_div_result_valid = 1'b1;
                    i_div_result = 16'h7FFF;
                end
                @(posedge clk); #1;
                i_div_ready = 1'b0;
                q = (dvs == '0) ? 32'sd0 : dvd / $signed({16'b0, dvs});
                i_div_result_valid = 1'b1;
                i_div_result = q[P-1:0];
                @(posedge clk); #1;
                i_div_result_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expected writes and divider requests as the DUT presents them.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_cent_wr_en) begin
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 128'(o_cent_wr_addr), 128'(e.a));
                    check("wr_data", 128'(o_cent_wr_data), 128'(e.d));
                end
            end
            if (o_div_valid) begin
                if (exp_div.size() == 0) fail_now("unexpected_div_req");
                else begin
                    check("div_dividend", 128'(o_div_dividend), 128'(exp_div[0].dvd));
                    check("div_divisor", 128'(o_div_divisor), 128'(exp_div[0].dvs));
                    if (i_div_ready) begin
                        void'(exp_div.pop_front());
                        req_cnt++;
                    end
                end
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic wait_done(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (o_done) break;
        end
        if (i == max_cyc) fail_now("timeout_waiting_done");
    endtask

    task automatic set_zero_mem();
        for (int i = 0; i < KC; i++) begin
            m_sum[i] = '0;
            m_cnt[i] = '0;
            m_old[i] = p16(i, i, i, i);
        end
    endtask

    task automatic push_writes(input int upto, input int ck, input logic [DW-1:0] cdata);
        for (int i = 0; i <= upto; i++) begin
            wr_t e;
            e.a = AB'(i);
            e.d = (i == ck) ? cdata : p16(i, i, i, i);
            exp_wr.push_back(e);
        end
    endtask

    task automatic push_div(input int a, input int b, input int c, input int e, input int cnt);
        int v[4];
        v = '{a, b, c, e};
        for (int i = 0; i < 4; i++) begin
            div_t x;
            x.dvd = 32'(v[i]);
            x.dvs = 16'(cnt);
            exp_div.push_back(x);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 128'({o_done, o_busy, o_acc_rd_en, o_div_valid, o_cent_wr_en}), 128'(0));
        check({tag, "_addr"}, 128'({o_acc_rd_addr, o_cent_wr_addr}), 128'(0));
        check({tag, "_div"}, 128'({o_div_dividend, o_div_divisor}), 128'(0));
        check({tag, "_wdata"}, 128'(o_cent_wr_data), 128'(0));
    endtask

    initial begin
        int s_cyc, d0, r0;
        reset_n = 1'b0;
        i_start = 1'b0;
        set_zero_mem();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Run 1: every cluster empty, start dropped mid-run.
        push_writes(9, -1, '0);
        d0 = done_cnt; r0 = req_cnt;
        s_cyc = cyc;
        i_start = 1'b1;
        repeat (5) @(negedge clk);
        i_start = 1'b0;
        wait_done(200);
        repeat (2) @(negedge clk);
        check("empty_last_wr_latency", 128'(last_wr_cyc - s_cyc), 128'(30));
        check("empty_done_pulses", 128'(done_cnt - d0), 128'(1));
        check("empty_no_div", 128'(req_cnt - r0), 128'(0));
        check("empty_idle_after", 128'(o_busy), 128'(0));

        // Run 2: cluster 3 divided, divider immediately ready.
        m_sum[3] = p32(100, 200, -40, 8);
        m_cnt[3] = 16'd4;
        push_writes(9, 3, p16(25, 50, -10, 2));
        push_div(100, 200, -40, 8, 4);
        d0 = done_cnt; r0 = req_cnt;
        s_cyc = cyc;
        i_start = 1'b1;
        wait_done(300);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("div_last_wr_latency", 128'(last_wr_cyc - s_cyc), 128'(38));
        check("div_req_count", 128'(req_cnt - r0), 128'(4));

        // Run 3: divider stalls ready for 5 cycles per request.
        m_cnt[3] = '0;
        m_sum[7] = p32(-300, 75, 0, 33);
        m_cnt[7] = 16'd3;
        ready_delay = 5;
        push_writes(9, 7, p16(-100, 25, 0, 11));
        push_div(-300, 75, 0, 33, 3);
        r0 = req_cnt;
        i_start = 1'b1;
        wait_done(400);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_req_count", 128'(req_cnt - r0), 128'(4));

        // Run 4: junk result coincides with each request handshake.
        m_cnt[7] = '0;
        m_sum[2] = p32(9, -9, 1000, 7);
        m_cnt[2] = 16'd2;
        ready_delay = 0;
        spurious = 1'b1;
        push_writes(9, 2, p16(4, -4, 500, 3));
        push_div(9, -9, 1000, 7, 2);
        i_start = 1'b1;
        wait_done(300);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        spurious = 1'b0;
        m_cnt[2] = '0;

        // Run 5: start held long after done.
        push_writes(9, -1, '0);
        d0 = done_cnt;
        i_start = 1'b1;
        wait_done(200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("held_start_busy", 128'(o_busy), 128'(1));
        end
        check("held_start_single_done", 128'(done_cnt - d0), 128'(1));
        i_start = 1'b0;
        @(negedge clk);
        check("held_start_idle_next", 128'(o_busy), 128'(0));

        // Run 6: reset during cluster 5 division, then a clean rerun.
        m_sum[5] = p32(10, 20, 30, 40);
        m_cnt[5] = 16'd2;
        ready_delay = 5;
        push_writes(4, -1, '0);
        push_div(10, 20, 30, 40, 2);
        i_start = 1'b1;
        begin
            int i;
            for (i = 0; i < 100; i++) begin
                @(negedge clk);
                if (o_div_valid) break;
            end
            if (i == 100) fail_now("timeout_waiting_div5");
        end
        check("rst_mid_addr", 128'(o_acc_rd_addr), 128'(5));
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        check("rst_mid_writes_done", 128'(exp_wr.size()), 128'(0));
        exp_div.delete();
        i_start = 1'b0;
        repeat (12) @(negedge clk);
        reset_n = 1'b1;
        ready_delay = 0;
        m_cnt[5] = '0;
        @(negedge clk);
        push_writes(9, -1, '0);
        i_start = 1'b1;
        wait_done(200);
        i_start = 1'b0;
        repeat (3) @(negedge clk);

        check("final_wr_queue_empty", 128'(exp_wr.size()), 128'(0));
        check("final_div_queue_empty", 128'(exp_div.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
